// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    localparam int DATASIZE_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } tx_state_t;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Free-running bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last count.
module uart_baud_cnt
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = !clear && (r_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one word at a time from a synchronous FIFO and
// sends it as start bit, DATASIZE data bits (LSB first) and one stop bit.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATASIZE     = DATASIZE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] fifo_rdata,
    input  logic                fifo_rempty,
    output logic                fifo_r_en,
    output logic                txd,
    output logic                busy,
    output logic                frame_done
);

    localparam int BIT_W = cnt_width(DATASIZE);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATASIZE - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (DATASIZE < 1) begin : g_bad_datasize
        $error("fifo_uart_tx: DATASIZE must be >= 1");
    end

    tx_state_t           r_state;
    tx_state_t           w_state_nxt;
    logic [DATASIZE-1:0] r_shreg;
    logic [DATASIZE-1:0] w_shreg_nxt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [BIT_W-1:0]    w_bit_cnt_nxt;
    logic                r_txd;
    logic                w_txd_nxt;
    logic                w_tick;
    logic                w_baud_clr;

    // Holding the counter clear until START makes START a full bit period.
    assign w_baud_clr = (r_state == S_IDLE) || (r_state == S_FETCH);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(w_baud_clr),
        .tick (w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        case (r_state)
            S_IDLE: begin
                if (!fifo_rempty) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_shreg_nxt   = fifo_rdata;
                w_bit_cnt_nxt = '0;
                w_state_nxt   = S_START;
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_shreg_nxt   = r_shreg >> 1;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The line level is derived from the next state so txd lines up with the state register.
    always_comb begin
        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shreg_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_txd     <= w_txd_nxt;
        end
    end

    // Gating with rst keeps the FIFO untouched while reset is held.
    assign fifo_r_en  = !rst && (r_state == S_IDLE) && !fifo_rempty;
    assign txd        = r_txd;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_STOP) && w_tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural 16-deep FIFO, line monitor and byte scoreboard.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
    localparam int FL  = 10 * CPB;

    logic          clk;
    logic          rst;
    logic          fifo_rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rempty;
    logic          fifo_r_en;
    logic          txd;
    logic          busy;
    logic          frame_done;

    logic [DW-1:0] mem [16];
    logic [3:0]    wp;
    logic [3:0]    rp;
    logic [4:0]    cnt;
    logic          do_wr;
    logic          do_rd;

    int            n_chk = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q [$];
    int            gap_q [$];
    int            pop_cnt = 0;
    int            fd_cnt  = 0;
    bit            mon_act = 1'b0;
    int            mon_off = 0;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATASIZE    (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_rdata (fifo_rdata),
        .fifo_rempty(fifo_rempty),
        .fifo_r_en  (fifo_r_en),
        .txd        (txd),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous FIFO: read data appears the cycle after a pop.
    assign do_wr       = wr_en && (cnt != 5'd16);
    assign do_rd       = fifo_r_en && (cnt != 5'd0);
    assign fifo_rempty = (cnt == 5'd0);

    always @(posedge clk) begin
        if (fifo_rst) begin
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            fifo_rdata <= '0;
        end else begin
            if (do_wr) begin
                mem[wp] <= wr_data;
                wp      <= wp + 4'd1;
            end
            if (do_rd) begin
                fifo_rdata <= mem[rp];
                rp         <= rp + 4'd1;
            end
            cnt <= cnt + {4'd0, do_wr} - {4'd0, do_rd};
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] frame_wave(input logic [DW-1:0] b);
        logic [63:0] w;
        int          slot;
        w = '0;
        for (int i = 0; i < FL; i++) begin
            slot = i / CPB;
            if (slot == 0)       w[i] = 1'b0;
            else if (slot <= DW) w[i] = b[slot-1];
            else                 w[i] = 1'b1;
        end
        return w;
    endfunction

    // Line monitor: per-cycle protocol checks and frame capture against the scoreboard.
    initial begin
        bit            fd_prev;
        bit            busy_bad;
        int            gap;
        logic [63:0]   aw;
        logic [63:0]   ew;
        logic [63:0]   fdm;
        logic [DW-1:0] eb;
        logic [DW-1:0] db;
        fd_prev  = 1'b0;
        busy_bad = 1'b0;
        gap      = 1000;
        aw       = '0;
        ew       = '0;
        fdm      = '0;
        eb       = '0;
        db       = '0;
        forever begin
            @(negedge clk);
            chk("ren_while_empty", 64'(fifo_r_en & fifo_rempty), 64'd0);
            chk("frame_done_width", 64'(frame_done & fd_prev), 64'd0);
            fd_prev = frame_done;
            if (frame_done) fd_cnt++;
            if (fifo_r_en) pop_cnt++;
            if (rst) begin
                mon_act = 1'b0;
                mon_off = 0;
                gap     = 1000;
            end else begin
                if (!mon_act) begin
                    if (txd == 1'b0) begin
                        mon_act  = 1'b1;
                        mon_off  = 0;
                        aw       = '0;
                        fdm      = '0;
                        busy_bad = 1'b0;
                        gap_q.push_back(gap);
                        if (exp_q.size() == 0) begin
                            chk("sb_unexpected_frame", 64'd1, 64'd0);
                            eb = '0;
                        end else begin
                            eb = exp_q.pop_front();
                        end
                        ew = frame_wave(eb);
                    end else if (gap < 1000) begin
                        gap++;
                    end
                end
                if (mon_act) begin
                    aw[mon_off]  = txd;
                    fdm[mon_off] = frame_done;
                    if (!busy) busy_bad = 1'b1;
                    if (mon_off == FL - 1) begin
                        for (int i = 0; i < DW; i++) db[i] = aw[CPB*(i+1) + CPB/2];
                        chk("rx_byte", 64'(db), 64'(eb));
                        chk("rx_wave", aw, ew);
                        chk("rx_frame_done_pos", fdm, 64'd1 << (FL - 1));
                        chk("rx_busy_in_frame", 64'(busy_bad), 64'd0);
                        mon_act = 1'b0;
                        gap     = 0;
                    end else begin
                        mon_off++;
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [DW-1:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !mon_act && !busy && fifo_rempty) ok = 1'b1;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        int ren_seen;
        int low_seen;
        int busy_seen;
        int pc0;
        int fd0;
        int early;
        bit ok;
        rst      = 1'b1;
        fifo_rst = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_txd", 64'(txd), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_r_en", 64'(fifo_r_en), 64'd0);
        fifo_rst = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;

        // Empty FIFO: the line must stay quiet.
        ren_seen  = 0;
        low_seen  = 0;
        busy_seen = 0;
        repeat (50) begin
            @(negedge clk);
            #1;
            if (fifo_r_en) ren_seen++;
            if (!txd) low_seen++;
            if (busy) busy_seen++;
        end
        chk("idle_r_en", 64'(ren_seen), 64'd0);
        chk("idle_txd_low", 64'(low_seen), 64'd0);
        chk("idle_busy", 64'(busy_seen), 64'd0);

        // Single byte.
        pc0 = pop_cnt;
        fd0 = fd_cnt;
        push_byte(8'hA5);
        wait_idle(200, "a5_complete");
        chk("a5_pops", 64'(pop_cnt - pc0), 64'd1);
        chk("a5_frame_done", 64'(fd_cnt - fd0), 64'd1);
        chk("a5_busy_after", 64'(busy), 64'd0);

        // Full FIFO drained back to back.
        gap_q.delete();
        pc0 = pop_cnt;
        fd0 = fd_cnt;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        wait_idle(16 * (FL + 2) + 100, "fill_complete");
        chk("fill_pops", 64'(pop_cnt - pc0), 64'd16);
        chk("fill_frame_done", 64'(fd_cnt - fd0), 64'd16);
        chk("fill_frames", 64'(gap_q.size()), 64'd16);
        for (int i = 1; i < gap_q.size(); i++) chk("fill_gap", 64'(gap_q[i]), 64'd2);
        chk("fill_rempty", 64'(fifo_rempty), 64'd1);

        // Byte written mid-frame waits for the current frame to finish.
        push_byte(8'h11);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (mon_act && mon_off >= 8) ok = 1'b1;
        end
        chk("mid_frame_reached", 64'(ok), 64'd1);
        push_byte(8'h3C);
        early = 0;
        ok    = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (fifo_r_en) early++;
            if (frame_done) ok = 1'b1;
        end
        chk("mid_frame_done_seen", 64'(ok), 64'd1);
        chk("mid_no_early_pop", 64'(early), 64'd0);
        @(negedge clk);
        #1;
        chk("mid_pop_after_done", 64'(fifo_r_en), 64'd1);
        wait_idle(200, "mid_complete");

        // Reset during data bit 3 of 0x5A; 0xC3 stays queued.
        push_byte(8'h5A);
        push_byte(8'hC3);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (mon_act && mon_off == 4 * CPB + 1) ok = 1'b1;
        end
        chk("abort_bit3_reached", 64'(ok), 64'd1);
        fd0 = fd_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("abort_txd", 64'(txd), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_frame_done", 64'(frame_done), 64'd0);
        chk("abort_r_en", 64'(fifo_r_en), 64'd0);
        @(negedge clk);
        #1;
        chk("abort_fifo_pending", 64'(fifo_rempty), 64'd0);
        chk("abort_r_en_held", 64'(fifo_r_en), 64'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        chk("abort_no_frame_done", 64'(fd_cnt - fd0), 64'd0);
        wait_idle(200, "abort_next_complete");
        chk("abort_next_frame_done", 64'(fd_cnt - fd0), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
